xio_mem_arbiter: RTL and testbench

- Shares the single external memory port behind the XIO memory apertures between two requesters.
- Port A is the A8 bus aperture path (page-mapped A8 reads/writes; hard real-time, must finish inside one 558 ns A8 cycle). Port B is the auxiliary requester (host/DMA side).
- Grants strictly favour A. B is held off during A8 windows flagged by a_reserve. Every transfer is timeout-guarded so a hung memory cannot stall the A8 bus.
- Sits between the aperture decode logic and the memory controller, in the 200 MHz clk domain.

---
 rtl/xio_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_xio_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xio_mem_arbiter.sv
// xio_mem_arbiter: shares one external memory port between the A8 aperture
// path (port A, strict priority) and an auxiliary requester (port B).
//
// Ports:
//   clk, rst_n                     200 MHz clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata      port A request (held until a_ack)
//   a_ack/a_rdata/a_err            port A 1-cycle completion, data, abort flag
//   b_*                            port B, same handshake as port A
//   a_reserve                      blocks new B grants while high
//   mem_req/mem_we/mem_addr/...    memory controller request side
//   mem_ack/mem_rdata              memory completion (1 cycle) and read data
//   gnt_a, gnt_b                   current owner of the memory port
//   err_cnt                        saturating count of timed-out transfers
module xio_mem_arbiter #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  input  logic              a_reserve,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_XFER_A = 2'd1;
  localparam logic [1:0] S_XFER_B = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state,     state_d;
  logic [CNT_W-1:0]  cnt,       cnt_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              gnt_a_d,   gnt_b_d;
  logic              a_ack_d,   b_ack_d;
  logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
  logic              a_err_d,   b_err_d;
  logic [ERR_W-1:0]  err_cnt_d;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      a_err     <= 1'b0;
      b_err     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      gnt_a     <= gnt_a_d;
      gnt_b     <= gnt_b_d;
      a_ack     <= a_ack_d;
      b_ack     <= b_ack_d;
      a_rdata   <= a_rdata_d;
      b_rdata   <= b_rdata_d;
      a_err     <= a_err_d;
      b_err     <= b_err_d;
      err_cnt   <= err_cnt_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    gnt_a_d     = gnt_a;
    gnt_b_d     = gnt_b;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata;
    b_rdata_d   = b_rdata;
    a_err_d     = a_err;
    b_err_d     = b_err;
    err_cnt_d   = err_cnt;

    case (state)
      S_IDLE: begin
        // A has absolute priority; B only starts outside reserved A8 windows
        if (a_req) begin
          state_d     = S_XFER_A;
          gnt_a_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = a_we;
          mem_addr_d  = a_addr;
          mem_wdata_d = a_wdata;
          cnt_d       = '0;
        end else if (b_req && !a_reserve) begin
          state_d     = S_XFER_B;
          gnt_b_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = b_we;
          mem_addr_d  = b_addr;
          mem_wdata_d = b_wdata;
          cnt_d       = '0;
        end
      end

      S_XFER_A, S_XFER_B: begin
        // An ack in the expiry cycle still wins over the abort
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          if (state == S_XFER_A) begin
            a_ack_d = 1'b1;
            a_err_d = 1'b0;
            if (!mem_we) a_rdata_d = mem_rdata;
          end else begin
            b_ack_d = 1'b1;
            b_err_d = 1'b0;
            if (!mem_we) b_rdata_d = mem_rdata;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          if (err_cnt != '1) err_cnt_d = err_cnt + ERR_W'(1);
          if (state == S_XFER_A) begin
            a_ack_d   = 1'b1;
            a_err_d   = 1'b1;
            a_rdata_d = '1;
          end else begin
            b_ack_d   = 1'b1;
            b_err_d   = 1'b1;
            b_rdata_d = '1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        // Completion cycle; requests are deliberately not sampled here
        state_d = S_IDLE;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        gnt_a_d   = 1'b0;
        gnt_b_d   = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_xio_mem_arbiter.sv
// tb_xio_mem_arbiter: directed bench for xio_mem_arbiter with a
// transaction-level reference model compared on every cycle.
module tb_xio_mem_arbiter;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned ERR_W   = 8;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  logic              clk, rst_n;
  logic              a_req, a_we, b_req, b_we, a_reserve;
  logic [ADDR_W-1:0] a_addr, b_addr, mem_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic              a_ack, a_err, b_ack, b_err;
  logic              mem_req, mem_we, mem_ack, gnt_a, gnt_b;
  logic [ERR_W-1:0]  err_cnt;

  xio_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .a_reserve(a_reserve),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic              exp_mem_req = 0, exp_mem_we = 0, exp_gnt_a = 0, exp_gnt_b = 0;
  logic [ADDR_W-1:0] exp_mem_addr = 0;
  logic [DATA_W-1:0] exp_mem_wdata = 0, exp_a_rdata = 0, exp_b_rdata = 0;
  logic              exp_a_ack = 0, exp_b_ack = 0, exp_a_err = 0, exp_b_err = 0;
  int                exp_err_cnt = 0;
  int                m_owner = 0;   // 0 none, 1 A, 2 B
  int                m_age   = 0;   // cycles mem_req has been high
  bit                m_done  = 0;   // completion cycle in progress

  task automatic model_finish(input bit timed_out);
    exp_mem_req = 1'b0;
    if (timed_out && exp_err_cnt < ERR_MAX) exp_err_cnt++;
    if (m_owner == 1) begin
      exp_a_ack = 1'b1;
      exp_a_err = timed_out;
      if (timed_out) exp_a_rdata = '1;
      else if (!exp_mem_we) exp_a_rdata = mem_rdata;
    end else begin
      exp_b_ack = 1'b1;
      exp_b_err = timed_out;
      if (timed_out) exp_b_rdata = '1;
      else if (!exp_mem_we) exp_b_rdata = mem_rdata;
    end
    m_owner = 0;
    m_done  = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_mem_req = 0; exp_mem_we = 0; exp_mem_addr = 0; exp_mem_wdata = 0;
      exp_gnt_a = 0; exp_gnt_b = 0; exp_a_ack = 0; exp_b_ack = 0;
      exp_a_rdata = 0; exp_b_rdata = 0; exp_a_err = 0; exp_b_err = 0;
      exp_err_cnt = 0; m_owner = 0; m_age = 0; m_done = 0;
    end else begin
      exp_a_ack = 1'b0;
      exp_b_ack = 1'b0;
      if (m_done) begin
        exp_gnt_a = 1'b0;
        exp_gnt_b = 1'b0;
        m_done    = 1'b0;
      end else if (m_owner != 0) begin
        if (mem_ack) model_finish(1'b0);
        else if (m_age == TIMEOUT) model_finish(1'b1);
        else m_age++;
      end else if (a_req) begin
        m_owner = 1; m_age = 1; exp_gnt_a = 1'b1; exp_mem_req = 1'b1;
        exp_mem_we = a_we; exp_mem_addr = a_addr; exp_mem_wdata = a_wdata;
      end else if (b_req && !a_reserve) begin
        m_owner = 2; m_age = 1; exp_gnt_b = 1'b1; exp_mem_req = 1'b1;
        exp_mem_we = b_we; exp_mem_addr = b_addr; exp_mem_wdata = b_wdata;
      end
    end
  end

  // ---------------- memory responder ----------------
  int resp_delay = 3;
  int rcnt = 0;
  int late_req = 0, late_done = 0;
  int last_mack_cyc = -1;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (rcnt == resp_delay) begin
          mem_ack       = 1'b1;
          mem_rdata     = mem_addr[7:0] ^ 8'h58;
          last_mack_cyc = cyc;
        end else begin
          mem_ack = 1'b0;
        end
        rcnt++;
      end else begin
        rcnt = 0;
        if (late_req != late_done) begin
          mem_ack   = 1'b1;
          mem_rdata = 8'hC3;
          late_done++;
        end else begin
          mem_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare and event monitor ----------------
  logic mreq_prev = 0, gnta_prev = 0, gntb_prev = 0;
  int mreq_rise_cyc = 0, mreq_len = 0, mreq_rises = 0;
  logic [ADDR_W-1:0] mreq_addr_at_rise = 0;
  int gnt_a_rise = -1, gnt_b_rise = -1;
  int a_ack_cnt = 0, b_ack_cnt = 0, a_ack_cyc = -1, b_ack_cyc = -1;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("mem_req",   mem_req,   exp_mem_req);
      chk("mem_we",    mem_we,    exp_mem_we);
      chk("mem_addr",  mem_addr,  exp_mem_addr);
      chk("mem_wdata", mem_wdata, exp_mem_wdata);
      chk("gnt_a",     gnt_a,     exp_gnt_a);
      chk("gnt_b",     gnt_b,     exp_gnt_b);
      chk("gnt_excl",  gnt_a & gnt_b, 1'b0);
      chk("a_ack",     a_ack,     exp_a_ack);
      chk("a_rdata",   a_rdata,   exp_a_rdata);
      chk("a_err",     a_err,     exp_a_err);
      chk("b_ack",     b_ack,     exp_b_ack);
      chk("b_rdata",   b_rdata,   exp_b_rdata);
      chk("b_err",     b_err,     exp_b_err);
      chk("err_cnt",   err_cnt,   exp_err_cnt);
    end
    if (mem_req && !mreq_prev) begin
      mreq_rise_cyc = cyc; mreq_rises++; mreq_addr_at_rise = mem_addr;
    end
    if (!mem_req && mreq_prev) mreq_len = cyc - mreq_rise_cyc;
    if (gnt_a && !gnta_prev) gnt_a_rise = cyc;
    if (gnt_b && !gntb_prev) gnt_b_rise = cyc;
    if (a_ack) begin a_ack_cnt++; a_ack_cyc = cyc; end
    if (b_ack) begin b_ack_cnt++; b_ack_cyc = cyc; end
    mreq_prev = mem_req; gnta_prev = gnt_a; gntb_prev = gnt_b;
  end

  // ---------------- requester helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_a(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic start_b(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  task automatic wait_a(output logic [DATA_W-1:0] rd, output logic er);
    bit got = 1'b0;
    rd = '0; er = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (a_ack) begin got = 1'b1; rd = a_rdata; er = a_err; a_req = 1'b0; end
    end
    if (!got) begin chk("a_ack_wait", 1'b0, 1'b1); a_req = 1'b0; end
  endtask

  task automatic wait_b(output logic [DATA_W-1:0] rd, output logic er);
    bit got = 1'b0;
    rd = '0; er = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (b_ack) begin got = 1'b1; rd = b_rdata; er = b_err; b_req = 1'b0; end
    end
    if (!got) begin chk("b_ack_wait", 1'b0, 1'b1); b_req = 1'b0; end
  endtask

  task automatic wait_gnt_b();
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (gnt_b) got = 1'b1;
    end
    if (!got) chk("gnt_b_wait", 1'b0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              er_a, er_b;
  int                r_cyc, acks0;

  initial begin
    rst_n = 1'b1; a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; a_reserve = 0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_err_cnt", err_cnt, 8'h00);
    chk("reset_a_ack",   a_ack,   1'b0);

    // A read, memory acks 3 cycles after mem_req
    resp_delay = 3;
    start_a(1'b0, 24'h000602, 8'h00);
    wait_a(rd_a, er_a);
    chk("rd_mem_req_len", mreq_len, 4);
    chk("rd_mem_addr",    mreq_addr_at_rise, 24'h000602);
    chk("rd_ack_lat",     a_ack_cyc - last_mack_cyc, 1);
    chk("rd_a_rdata",     rd_a, 8'h5A);
    chk("rd_a_err",       er_a, 1'b0);
    tick();

    // Simultaneous A write and B read: A first, bubble, then B
    resp_delay = 2;
    fork
      begin start_a(1'b1, 24'h000100, 8'h65); wait_a(rd_a, er_a); end
      begin start_b(1'b0, 24'h000200, 8'h00); wait_b(rd_b, er_b); end
    join
    chk("sim_order",    a_ack_cyc < b_ack_cyc, 1'b1);
    chk("sim_b_grant",  gnt_b_rise, a_ack_cyc + 2);
    chk("sim_a_rdata",  rd_a, 8'h5A);
    chk("sim_b_rdata",  rd_b, 8'h58);
    tick();

    // a_reserve holds B off for 20 cycles
    a_reserve = 1'b1;
    start_b(1'b0, 24'h000210, 8'h00);
    acks0 = mreq_rises;
    repeat (20) tick();
    chk("rsv_no_req", mreq_rises - acks0, 0);
    a_reserve = 1'b0;
    r_cyc = cyc;
    wait_b(rd_b, er_b);
    chk("rsv_grant_cyc", gnt_b_rise, r_cyc + 1);
    chk("rsv_b_rdata",   rd_b, 8'h48);
    tick();

    // A arrives while B is in flight
    resp_delay = 5;
    start_b(1'b0, 24'h000444, 8'h00);
    wait_gnt_b();
    tick(); tick();
    start_a(1'b0, 24'h000333, 8'h00);
    fork
      wait_b(rd_b, er_b);
      wait_a(rd_a, er_a);
    join
    chk("fly_b_rdata", rd_b, 8'h1C);
    chk("fly_b_err",   er_b, 1'b0);
    chk("fly_a_grant", gnt_a_rise, b_ack_cyc + 2);
    chk("fly_a_rdata", rd_a, 8'h6B);
    tick();

    // Timeout, late ack, saturation
    resp_delay = 1000;
    start_a(1'b0, 24'h000777, 8'h00);
    wait_a(rd_a, er_a);
    chk("to_mem_req_len", mreq_len, 32);
    chk("to_a_rdata",     rd_a, 8'hFF);
    chk("to_a_err",       er_a, 1'b1);
    chk("to_err_cnt",     err_cnt, 8'd1);
    acks0 = a_ack_cnt;
    repeat (4) tick();
    late_req++;
    repeat (4) tick();
    chk("late_err_cnt", err_cnt, 8'd1);
    chk("late_no_ack",  a_ack_cnt - acks0, 0);
    for (int i = 0; i < 299; i++) begin
      start_a(1'b0, 24'h000777, 8'h00);
      wait_a(rd_a, er_a);
    end
    tick();
    chk("sat_err_cnt", err_cnt, 8'hFF);
    chk("sat_a_err",   a_err, 1'b1);

    // Reset in the middle of a B transfer
    start_b(1'b0, 24'h000555, 8'h00);
    wait_gnt_b();
    tick(); tick();
    acks0 = b_ack_cnt;
    start_a(1'b0, 24'h000602, 8'h00);
    rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_gnt_b",   gnt_b,   1'b0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    resp_delay = 2;
    tick(); tick();
    rst_n = 1'b1;
    r_cyc = cyc;
    wait_a(rd_a, er_a);
    chk("rst_a_grant", gnt_a_rise, r_cyc + 1);
    chk("rst_no_b_ack", b_ack_cnt - acks0, 0);
    chk("rst_a_rdata", rd_a, 8'h5A);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
